aig_tt_sweeper: RTL and testbench

AIG_TT_SWEEPER -- requirements
Module: aig_tt_sweeper

---
 rtl/aig_tt_sweeper.sv | 128 ++++++++++++
 tb/tb_aig_tt_sweeper.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aig_tt_sweeper.sv
// Truth-table sweeper for a 6-input AIG: walks x_o over 0..63, samples z_i, reports the table.
// Optional macro AIG_TT_SWEEPER_ONES_EN adds ones_o, the population count of the captured table.
module aig_tt_sweeper #(
  parameter int unsigned SETTLE = 0,
  parameter logic [63:0] EXP_TT = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clr,
  output logic [5:0]  x_o,
  input  logic        z_i,
  output logic        busy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] tt_o,
  output logic        match_o
`ifdef AIG_TT_SWEEPER_ONES_EN
  ,
  output logic [6:0]  ones_o
`endif
);

  localparam logic [3:0] SETTLE_C = SETTLE[3:0];

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t      state_q;
  logic [5:0]  idx_q;
  logic [3:0]  cnt_q;
  logic [62:0] acc_q;
  logic [63:0] tt_q;
  logic        match_q;
  logic        busy_q;
  logic        valid_q;
  logic        hold_end;
  logic [63:0] full_tt;

  assign hold_end = (cnt_q == SETTLE_C);
  // Bit 63 is folded in straight from z_i so the final table is complete on the DONE edge.
  assign full_tt  = {z_i, acc_q};

`ifdef AIG_TT_SWEEPER_ONES_EN
  logic [6:0] ones_q;
  logic [6:0] ones_d;

  always_comb begin
    ones_d = 7'd0;
    for (int i = 0; i < 64; i++) begin
      ones_d = ones_d + {6'd0, full_tt[i]};
    end
  end

  assign ones_o = ones_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 6'd0;
      cnt_q   <= 4'd0;
      acc_q   <= '0;
      tt_q    <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef AIG_TT_SWEEPER_ONES_EN
      ones_q  <= 7'd0;
`endif
    end else if (clr) begin
      state_q <= IDLE;
      idx_q   <= 6'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SWEEP;
            idx_q   <= 6'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          if (hold_end) begin
            cnt_q <= 4'd0;
            idx_q <= idx_q + 6'd1;
            if (idx_q == 6'd63) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              tt_q    <= full_tt;
              match_q <= (full_tt == EXP_TT);
`ifdef AIG_TT_SWEEPER_ONES_EN
              ones_q  <= ones_d;
`endif
            end else begin
              acc_q[idx_q] <= z_i;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          // A start arriving with the handshake is dropped; only the handshake is honoured.
          if (res_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign x_o       = idx_q;
  assign busy      = busy_q;
  assign res_valid = valid_q;
  assign tt_o      = tt_q;
  assign match_o   = match_q;

endmodule

// File: tb/tb_aig_tt_sweeper.sv
// Scoreboard bench for aig_tt_sweeper: two instances (SETTLE=0 and SETTLE=3) driven by a table-level model.
// Define AIG_TT_SWEEPER_ONES_EN to also check ones_o.
module tb_aig_tt_sweeper;

  localparam logic [63:0] EXP0 = 64'hFFFFFFFF00000000;
  localparam logic [63:0] EXP3 = 64'h000000000F0FFFFF;

  typedef struct {
    logic [63:0] tt;
    logic        match;
    logic [6:0]  ones;
  } exp_t;

  logic        clk = 1'b0;
  logic        start_a [2];
  logic        clr_a   [2];
  logic        rdy_a   [2];
  logic        rstn_a  [2];
  logic [5:0]  x_w     [2];
  logic        z_w     [2];
  logic        busy_w  [2];
  logic        rv_w    [2];
  logic [63:0] tt_w    [2];
  logic        m_w     [2];
`ifdef AIG_TT_SWEEPER_ONES_EN
  logic [6:0]  ones_w  [2];
`endif

  int          zmode   [2];
  logic [63:0] rtt     [2];
  logic [63:0] last_tt [2];
  logic        prev_rv [2];
  exp_t        q0[$];
  exp_t        q1[$];
  int          checks   = 0;
  int          failures = 0;
  int          results  = 0;
  int          accepted = 0;

  always #5 clk = ~clk;

  function automatic logic zf(input int mode, input logic [5:0] x, input logic [63:0] t);
    case (mode)
      0:       return x[0];
      1:       return x[5];
      2:       return ~(x[4] & x[2]) & ~x[5];
      default: return t[x];
    endcase
  endfunction

  assign z_w[0] = zf(zmode[0], x_w[0], rtt[0]);
  assign z_w[1] = zf(zmode[1], x_w[1], rtt[1]);

  aig_tt_sweeper #(.SETTLE(0), .EXP_TT(EXP0)) dut0 (
    .clk(clk), .rst_n(rstn_a[0]), .start(start_a[0]), .clr(clr_a[0]),
    .x_o(x_w[0]), .z_i(z_w[0]), .busy(busy_w[0]), .res_valid(rv_w[0]),
    .res_ready(rdy_a[0]), .tt_o(tt_w[0]), .match_o(m_w[0])
`ifdef AIG_TT_SWEEPER_ONES_EN
    , .ones_o(ones_w[0])
`endif
  );

  aig_tt_sweeper #(.SETTLE(3), .EXP_TT(EXP3)) dut3 (
    .clk(clk), .rst_n(rstn_a[1]), .start(start_a[1]), .clr(clr_a[1]),
    .x_o(x_w[1]), .z_i(z_w[1]), .busy(busy_w[1]), .res_valid(rv_w[1]),
    .res_ready(rdy_a[1]), .tt_o(tt_w[1]), .match_o(m_w[1])
`ifdef AIG_TT_SWEEPER_ONES_EN
    , .ones_o(ones_w[1])
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int settle_of(input int sel);
    return (sel == 1) ? 3 : 0;
  endfunction

  // Reference: the table is simply f(i) for every i, independent of how the DUT walks it.
  function automatic exp_t model(input int sel);
    exp_t e;
    for (int i = 0; i < 64; i++) e.tt[i] = zf(zmode[sel], 6'(i), rtt[sel]);
    e.match = (e.tt == ((sel == 1) ? EXP3 : EXP0));
    e.ones  = 7'($countones(e.tt));
    return e;
  endfunction

  task automatic push_exp(input int sel, input exp_t e);
    if (sel == 1) q1.push_back(e); else q0.push_back(e);
  endtask

  task automatic drop_exp(input int sel);
    if (sel == 1) void'(q1.pop_back()); else void'(q0.pop_back());
  endtask

  task automatic cmp_res(input int k);
    exp_t e;
    results++;
    if ((k == 1 && q1.size() == 0) || (k == 0 && q0.size() == 0)) begin
      chk($sformatf("unexpected_result_dut%0d", k), 64'd1, 64'd0);
    end else begin
      e = (k == 1) ? q1.pop_front() : q0.pop_front();
      chk($sformatf("sb_tt_dut%0d", k), tt_w[k], e.tt);
      chk($sformatf("sb_match_dut%0d", k), 64'(m_w[k]), 64'(e.match));
`ifdef AIG_TT_SWEEPER_ONES_EN
      chk($sformatf("sb_ones_dut%0d", k), 64'(ones_w[k]), 64'(e.ones));
`endif
      $display("result dut%0d tt=%h match=%0b", k, tt_w[k], m_w[k]);
    end
  endtask

  // Monitor: a result is consumed from the scoreboard on each rising edge of res_valid.
  always @(negedge clk) begin
    if (rv_w[0] && !prev_rv[0]) cmp_res(0);
    if (rv_w[1] && !prev_rv[1]) cmp_res(1);
    prev_rv[0] <= rv_w[0];
    prev_rv[1] <= rv_w[1];
  end

  task automatic run_sweep(input int sel, input int delay, input bit start_mid, input bit start_hs);
    exp_t e;
    int   s    = settle_of(sel);
    int   len  = 64 * (s + 1);
    int   cyc  = 0;
    int   xerr = 0;
    int   berr = 0;
    bit   done = 0;
    e = model(sel);
    @(negedge clk);
    start_a[sel] = 1'b1;
    push_exp(sel, e);
    accepted++;
    while (!done && cyc < len + 20) begin
      @(negedge clk);
      cyc++;
      start_a[sel] = (start_mid && cyc == 10);
      if (rv_w[sel]) done = 1;
      else if (x_w[sel] !== 6'((cyc - 1) / (s + 1)) || busy_w[sel] !== 1'b1) xerr++;
    end
    start_a[sel] = 1'b0;
    chk($sformatf("latency_dut%0d", sel), 64'(cyc - 1), 64'(len));
    chk($sformatf("x_hold_seq_dut%0d", sel), 64'(xerr), 64'd0);
    for (int d = 0; d < delay; d++) begin
      chk($sformatf("hold_valid_dut%0d", sel), 64'(rv_w[sel]), 64'd1);
      chk($sformatf("hold_tt_dut%0d", sel), tt_w[sel], e.tt);
      @(negedge clk);
    end
    rdy_a[sel]   = 1'b1;
    start_a[sel] = start_hs;
    @(negedge clk);
    rdy_a[sel]   = 1'b0;
    start_a[sel] = 1'b0;
    chk($sformatf("hs_valid_low_dut%0d", sel), 64'(rv_w[sel]), 64'd0);
    chk($sformatf("idle_tt_kept_dut%0d", sel), tt_w[sel], e.tt);
    repeat (4) begin
      @(negedge clk);
      if (busy_w[sel] !== 1'b0 || x_w[sel] !== 6'd0) berr++;
    end
    chk($sformatf("no_restart_dut%0d", sel), 64'(berr), 64'd0);
    last_tt[sel] = e.tt;
    $display("sweep dut%0d mode=%0d delay=%0d start_mid=%0b start_hs=%0b tt=%h",
             sel, zmode[sel], delay, start_mid, start_hs, e.tt);
  endtask

  task automatic run_abort(input int sel, input int target, input bit use_rst);
    int cyc = 0;
    exp_t e;
    e = model(sel);
    @(negedge clk);
    start_a[sel] = 1'b1;
    push_exp(sel, e);
    @(negedge clk);
    start_a[sel] = 1'b0;
    while (x_w[sel] !== 6'(target) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("reach_index_dut%0d", sel), 64'(x_w[sel]), 64'(target));
    drop_exp(sel);
    if (!use_rst) begin
      clr_a[sel] = 1'b1;
      @(negedge clk);
      clr_a[sel] = 1'b0;
      chk($sformatf("clr_busy_dut%0d", sel), 64'(busy_w[sel]), 64'd0);
      chk($sformatf("clr_x_dut%0d", sel), 64'(x_w[sel]), 64'd0);
      chk($sformatf("clr_valid_dut%0d", sel), 64'(rv_w[sel]), 64'd0);
      chk($sformatf("clr_tt_kept_dut%0d", sel), tt_w[sel], last_tt[sel]);
    end else begin
      #2 rstn_a[sel] = 1'b0;
      #1;
      chk($sformatf("arst_x_dut%0d", sel), 64'(x_w[sel]), 64'd0);
      chk($sformatf("arst_busy_dut%0d", sel), 64'(busy_w[sel]), 64'd0);
      chk($sformatf("arst_valid_dut%0d", sel), 64'(rv_w[sel]), 64'd0);
      chk($sformatf("arst_tt_dut%0d", sel), tt_w[sel], 64'd0);
      chk($sformatf("arst_match_dut%0d", sel), 64'(m_w[sel]), 64'd0);
`ifdef AIG_TT_SWEEPER_ONES_EN
      chk($sformatf("arst_ones_dut%0d", sel), 64'(ones_w[sel]), 64'd0);
`endif
      #1 rstn_a[sel] = 1'b1;
      @(negedge clk);
      chk($sformatf("post_rst_idle_dut%0d", sel), 64'(busy_w[sel]), 64'd0);
      chk($sformatf("post_rst_x_dut%0d", sel), 64'(x_w[sel]), 64'd0);
      last_tt[sel] = 64'd0;
    end
    $display("abort dut%0d at index %0d via %s", sel, target, use_rst ? "rst_n" : "clr");
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      start_a[k] = 1'b0; clr_a[k] = 1'b0; rdy_a[k] = 1'b0; rstn_a[k] = 1'b0;
      zmode[k] = 0; rtt[k] = 64'd0; last_tt[k] = 64'd0; prev_rv[k] = 1'b0;
    end
    #3;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_tt_dut%0d", k), tt_w[k], 64'd0);
      chk($sformatf("reset_busy_valid_dut%0d", k), {62'd0, busy_w[k], rv_w[k]}, 64'd0);
    end
    #9;
    rstn_a[0] = 1'b1;
    rstn_a[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("idle_after_release_dut%0d", k), {56'd0, x_w[k], busy_w[k], rv_w[k]}, 64'd0);
    end

    zmode[0] = 0;
    run_sweep(0, 2, 0, 0);
    chk("tt_x1_pattern", tt_w[0], 64'hAAAAAAAAAAAAAAAA);

    zmode[0] = 1;
    run_sweep(0, 1, 0, 0);
    chk("tt_x6_pattern", tt_w[0], 64'hFFFFFFFF00000000);

    zmode[1] = 2;
    run_sweep(1, 10, 0, 0);

    zmode[0] = 3;
    rtt[0]   = {$urandom, $urandom};
    run_abort(0, 20, 0);

    zmode[1] = 3;
    rtt[1]   = {$urandom, $urandom};
    run_abort(1, 40, 1);

    zmode[0] = 2;
    run_sweep(0, 3, 1, 1);

    for (int it = 0; it < 6; it++) begin
      int sel;
      sel = int'($urandom_range(0, 1));
      zmode[sel] = 3;
      rtt[sel]   = {$urandom, $urandom};
      run_sweep(sel, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(q0.size() + q1.size()), 64'd0);
    chk("result_count", 64'(results), 64'(accepted));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
